// File: rtl/wfq_top.sv
// wfq_top: weighted fair queuing scheduler with an integrated per-flow packet buffer.
// Packets are stamped with a virtual finish tag on arrival; reads drain one word at a
// time from the in-service flow, picking a new flow only at packet boundaries.
//
// state  | meaning
// S_IDLE | waiting for a read request
// S_SEL  | keep current flow or select flow with smallest head tag
// S_RD   | read the head word of the in-service flow
// S_OUT  | present the word on out_packet_data_out
module wfq_top #(
    parameter int                        NUM_FLOWS  = 4,
    parameter int                        FIFO_DEPTH = 256,
    parameter logic [NUM_FLOWS*16-1:0]   INV_WEIGHT = {16'd4, 16'd3, 16'd2, 16'd1},
    parameter int                        TAG_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_packet_arrival,
    input  logic        in_data_arrival,
    input  logic [8:0]  in_packet_length,
    input  logic [63:0] in_packet_data,
    input  logic [12:0] in_flow_id,
    input  logic        in_rd_packet_req,
    output logic        out_packet_buffer_empty,
    output logic [63:0] out_packet_data_out
);
    localparam int FW = $clog2(NUM_FLOWS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = FW + AW;
    localparam logic [PW:0] DEPTH_V = FIFO_DEPTH[PW:0];

    typedef enum logic [1:0] {S_IDLE, S_SEL, S_RD, S_OUT} state_t;

    // Word storage; tag and end-of-packet flag travel with every word
    logic [63:0]      r_mem_data [NUM_FLOWS*FIFO_DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [NUM_FLOWS*FIFO_DEPTH];
    logic             r_mem_last [NUM_FLOWS*FIFO_DEPTH];

    state_t           r_state, w_state_nxt;
    // r_wr_ptr only advances when a packet is complete, so partial packets are invisible
    logic [PW-1:0]    r_wr_ptr [NUM_FLOWS];
    logic [PW-1:0]    r_rd_ptr [NUM_FLOWS];
    logic [PW-1:0]    w_wr_ptr_nxt [NUM_FLOWS];
    logic [PW-1:0]    w_rd_ptr_nxt [NUM_FLOWS];
    logic [TAG_W-1:0] r_last_tag [NUM_FLOWS];
    logic [TAG_W-1:0] w_head_tag [NUM_FLOWS];
    logic [TAG_W-1:0] r_vtime;
    logic             r_in_srv;
    logic [FW-1:0]    r_srv_flow;
    logic [63:0]      r_rd_data;
    logic [63:0]      r_out_data;
    logic             r_empty;
    logic             w_empty_nxt;

    logic             r_wr_act;
    logic [FW-1:0]    r_wr_flow;
    logic [PW-1:0]    r_wr_addr;
    logic [8:0]       r_wr_left;
    logic [TAG_W-1:0] r_wr_tag;

    logic [FW-1:0]    w_arr_flow;
    logic             w_arrive;
    logic             w_flow_ok;
    logic [PW-1:0]    w_used;
    logic [PW:0]      w_free;
    logic             w_accept;
    logic             w_cont;
    logic [15:0]      w_weight;
    logic [TAG_W-1:0] w_base;
    logic [TAG_W-1:0] w_new_tag;
    logic             w_mem_we;
    logic [MW-1:0]    w_mem_waddr;
    logic [TAG_W-1:0] w_mem_tag;
    logic             w_mem_last;
    logic [MW-1:0]    w_rd_addr;
    logic             w_sel_found;
    logic [FW-1:0]    w_sel_flow;
    logic [TAG_W-1:0] w_sel_tag;
    logic             w_do_sel;
    logic             w_do_rd;

    assign w_arr_flow = in_flow_id[FW-1:0];
    assign w_arrive   = in_packet_arrival & in_data_arrival;
    assign w_flow_ok  = in_flow_id < 13'(NUM_FLOWS);
    assign w_used     = r_wr_ptr[w_arr_flow] - r_rd_ptr[w_arr_flow];
    assign w_free     = DEPTH_V - {1'b0, w_used};
    assign w_accept   = w_arrive & w_flow_ok & (in_packet_length != 9'd0)
                        & (32'(w_free) >= 32'(in_packet_length));
    assign w_cont     = r_wr_act & in_data_arrival & ~in_packet_arrival;
    assign w_weight   = INV_WEIGHT[16*w_arr_flow +: 16];
    assign w_base     = (r_vtime > r_last_tag[w_arr_flow]) ? r_vtime : r_last_tag[w_arr_flow];
    assign w_new_tag  = w_base + TAG_W'(in_packet_length) * TAG_W'(w_weight);
    assign w_rd_addr  = {r_srv_flow, r_rd_ptr[r_srv_flow][AW-1:0]};

    // Write port: first word of an accepted packet or a continuation word
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = '0;
        w_mem_tag   = '0;
        w_mem_last  = 1'b0;
        if (w_accept) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {w_arr_flow, r_wr_ptr[w_arr_flow][AW-1:0]};
            w_mem_tag   = w_new_tag;
            w_mem_last  = (in_packet_length == 9'd1);
        end else if (w_cont) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {r_wr_flow, r_wr_addr[AW-1:0]};
            w_mem_tag   = r_wr_tag;
            w_mem_last  = (r_wr_left == 9'd1);
        end
    end

    // Smallest head tag among committed flows; strict compare keeps ties at lowest index
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_flow  = '0;
        w_sel_tag   = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            w_head_tag[i] = r_mem_tag[{FW'(i), r_rd_ptr[i][AW-1:0]}];
            if (r_wr_ptr[i] != r_rd_ptr[i]) begin
                if (!w_sel_found || (w_head_tag[i] < w_sel_tag)) begin
                    w_sel_found = 1'b1;
                    w_sel_flow  = FW'(i);
                    w_sel_tag   = w_head_tag[i];
                end
            end
        end
    end

    // Read pipeline next state and strobes
    always_comb begin
        w_state_nxt = r_state;
        w_do_sel    = 1'b0;
        w_do_rd     = 1'b0;
        case (r_state)
            S_IDLE: if (in_rd_packet_req && !r_empty) w_state_nxt = S_SEL;
            S_SEL: begin
                if (r_in_srv) begin
                    w_state_nxt = S_RD;
                end else if (w_sel_found) begin
                    w_do_sel    = 1'b1;
                    w_state_nxt = S_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_do_rd     = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pointer updates for this cycle and the resulting occupancy
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_accept && (in_packet_length == 9'd1))
            w_wr_ptr_nxt[w_arr_flow] = r_wr_ptr[w_arr_flow] + PW'(1);
        else if (w_cont && (r_wr_left == 9'd1))
            w_wr_ptr_nxt[r_wr_flow] = r_wr_addr + PW'(1);
        if (w_do_rd)
            w_rd_ptr_nxt[r_srv_flow] = r_rd_ptr[r_srv_flow] + PW'(1);
        w_empty_nxt = 1'b1;
        for (int i = 0; i < NUM_FLOWS; i++)
            if (w_wr_ptr_nxt[i] != w_rd_ptr_nxt[i]) w_empty_nxt = 1'b0;
    end

    // Buffer memory write
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem_data[w_mem_waddr] <= in_packet_data;
            r_mem_tag[w_mem_waddr]  <= w_mem_tag;
            r_mem_last[w_mem_waddr] <= w_mem_last;
        end
    end

    // Control state: pointers, tags, virtual time, write tracking, read pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            for (int i = 0; i < NUM_FLOWS; i++) begin
                r_wr_ptr[i]   <= '0;
                r_rd_ptr[i]   <= '0;
                r_last_tag[i] <= '0;
            end
            r_vtime    <= '0;
            r_in_srv   <= 1'b0;
            r_srv_flow <= '0;
            r_rd_data  <= '0;
            r_out_data <= '0;
            r_empty    <= 1'b1;
            r_wr_act   <= 1'b0;
            r_wr_flow  <= '0;
            r_wr_addr  <= '0;
            r_wr_left  <= '0;
            r_wr_tag   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= w_empty_nxt;
            if (w_arrive) begin
                // a new arrival always abandons any unfinished packet
                r_wr_act  <= w_accept && (in_packet_length != 9'd1);
                r_wr_flow <= w_arr_flow;
                r_wr_addr <= r_wr_ptr[w_arr_flow] + PW'(1);
                r_wr_left <= in_packet_length - 9'd1;
                r_wr_tag  <= w_new_tag;
            end else if (w_cont) begin
                r_wr_addr <= r_wr_addr + PW'(1);
                r_wr_left <= r_wr_left - 9'd1;
                if (r_wr_left == 9'd1) r_wr_act <= 1'b0;
            end
            if (w_accept) r_last_tag[w_arr_flow] <= w_new_tag;
            if (w_do_sel) begin
                r_vtime    <= w_sel_tag;
                r_srv_flow <= w_sel_flow;
                r_in_srv   <= 1'b1;
            end
            if (w_do_rd) begin
                r_rd_data <= r_mem_data[w_rd_addr];
                if (r_mem_last[w_rd_addr]) r_in_srv <= 1'b0;
            end
            if (r_state == S_OUT) r_out_data <= r_rd_data;
        end
    end

    assign out_packet_buffer_empty = r_empty;
    assign out_packet_data_out     = r_out_data;
endmodule

// File: tb/tb_wfq_top.sv
// Directed bench for wfq_top: single-word vector table, fairness run, and
// multi-cycle corner sequences (no preemption, full drop, reset mid-read).
module tb_wfq_top;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_packet_arrival = 1'b0;
    logic        in_data_arrival = 1'b0;
    logic [8:0]  in_packet_length = '0;
    logic [63:0] in_packet_data = '0;
    logic [12:0] in_flow_id = '0;
    logic        in_rd_packet_req = 1'b0;
    logic        out_packet_buffer_empty;
    logic [63:0] out_packet_data_out;

    int errors = 0;
    int checks = 0;

    wfq_top dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_packet_arrival       (in_packet_arrival),
        .in_data_arrival         (in_data_arrival),
        .in_packet_length        (in_packet_length),
        .in_packet_data          (in_packet_data),
        .in_flow_id              (in_flow_id),
        .in_rd_packet_req        (in_rd_packet_req),
        .out_packet_buffer_empty (out_packet_buffer_empty),
        .out_packet_data_out     (out_packet_data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] flow;
        logic [8:0]  len;
        logic [63:0] data;
        logic [63:0] exp_out;
        logic        exp_empty_pre;
        logic        exp_empty_post;
    } vec_t;

    vec_t tv [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // length 0 still presents one word so the drop path is exercised
    task automatic send_pkt(input logic [12:0] flow, input logic [8:0] len, input logic [63:0] base);
        int n;
        n = (len == 9'd0) ? 1 : int'(len);
        for (int i = 0; i < n; i++) begin
            in_data_arrival   = 1'b1;
            in_packet_arrival = (i == 0);
            in_packet_length  = len;
            in_flow_id        = flow;
            in_packet_data    = base + 64'(i);
            @(negedge clk);
        end
        in_data_arrival   = 1'b0;
        in_packet_arrival = 1'b0;
    endtask

    // request at E0, sample after E3
    task automatic do_read(output logic [63:0] data);
        in_rd_packet_req = 1'b1;
        @(negedge clk);
        in_rd_packet_req = 1'b0;
        repeat (3) @(negedge clk);
        data = out_packet_data_out;
    endtask

    logic [63:0] rd;
    int served [4];
    int best_f;
    int best_t;
    int t;

    initial begin
        tv[0] = '{13'd2,    9'd1, 64'h2,  64'h2,  1'b0, 1'b1};
        tv[1] = '{13'd0,    9'd1, 64'h11, 64'h11, 1'b0, 1'b1};
        tv[2] = '{13'd3,    9'd1, 64'h33, 64'h33, 1'b0, 1'b1};
        tv[3] = '{13'd5,    9'd1, 64'h55, 64'h33, 1'b1, 1'b1};
        tv[4] = '{13'd1,    9'd0, 64'h66, 64'h33, 1'b1, 1'b1};
        tv[5] = '{13'd1,    9'd1, 64'h77, 64'h77, 1'b0, 1'b1};
        tv[6] = '{13'd4,    9'd1, 64'h88, 64'h77, 1'b1, 1'b1};
        tv[7] = '{13'h1fff, 9'd1, 64'h99, 64'h77, 1'b1, 1'b1};

        // reset state and ignored read while empty
        do_reset();
        check("reset_empty", 64'(out_packet_buffer_empty), 64'd1);
        check("reset_out", out_packet_data_out, 64'd0);
        do_read(rd);
        check("empty_read_out", rd, 64'd0);
        check("empty_read_empty", 64'(out_packet_buffer_empty), 64'd1);

        // table of single-packet enqueue + read
        for (int i = 0; i < 8; i++) begin
            send_pkt(tv[i].flow, tv[i].len, tv[i].data);
            check($sformatf("tv%0d_empty_pre", i), 64'(out_packet_buffer_empty), 64'(tv[i].exp_empty_pre));
            do_read(rd);
            check($sformatf("tv%0d_out", i), rd, tv[i].exp_out);
            check($sformatf("tv%0d_empty_post", i), 64'(out_packet_buffer_empty), 64'(tv[i].exp_empty_post));
        end

        // fairness: 256 rounds of 1-word packets, data = flow id, then 256 reads
        do_reset();
        for (int r = 0; r < 256; r++)
            for (int f = 0; f < 4; f++)
                send_pkt(13'(f), 9'd1, 64'(f));
        for (int f = 0; f < 4; f++) served[f] = 0;
        for (int k = 0; k < 256; k++) begin
            best_f = 0;
            best_t = 0;
            for (int f = 0; f < 4; f++) begin
                t = (served[f] + 1) * (f + 1);
                if (f == 0 || t < best_t) begin
                    best_f = f;
                    best_t = t;
                end
            end
            served[best_f]++;
            do_read(rd);
            check($sformatf("fair_rd%0d", k), rd, 64'(best_f));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        check("fair_cnt0", 64'(served[0]), 64'd124);
        check("fair_cnt1", 64'(served[1]), 64'd61);
        check("fair_cnt2", 64'(served[2]), 64'd41);
        check("fair_cnt3", 64'(served[3]), 64'd30);

        // no preemption: flow0 (tag 1) arrives at the selection edge of flow1 (tag 6)
        do_reset();
        send_pkt(13'd1, 9'd3, 64'h100);
        in_rd_packet_req = 1'b1;
        @(negedge clk);
        in_rd_packet_req  = 1'b0;
        in_data_arrival   = 1'b1;
        in_packet_arrival = 1'b1;
        in_packet_length  = 9'd1;
        in_flow_id        = 13'd0;
        in_packet_data    = 64'hF0;
        @(negedge clk);
        in_data_arrival   = 1'b0;
        in_packet_arrival = 1'b0;
        repeat (2) @(negedge clk);
        check("nopre_w0", out_packet_data_out, 64'h100);
        do_read(rd);
        check("nopre_w1", rd, 64'h101);
        do_read(rd);
        check("nopre_w2", rd, 64'h102);
        do_read(rd);
        check("nopre_f0", rd, 64'hF0);
        check("nopre_empty", 64'(out_packet_buffer_empty), 64'd1);

        // full flow drop and invalid flow drop
        do_reset();
        send_pkt(13'd3, 9'd256, 64'h3000);
        check("full_not_empty", 64'(out_packet_buffer_empty), 64'd0);
        send_pkt(13'd3, 9'd2, 64'h3900);
        send_pkt(13'd0, 9'd1, 64'hA0);
        send_pkt(13'd5, 9'd1, 64'hBAD);
        do_read(rd);
        check("full_f0_first", rd, 64'hA0);
        for (int i = 0; i < 256; i++) begin
            do_read(rd);
            check($sformatf("full_f3_w%0d", i), rd, 64'h3000 + 64'(i));
        end
        check("full_drained_empty", 64'(out_packet_buffer_empty), 64'd1);
        do_read(rd);
        check("full_extra_read", rd, 64'h30FF);

        // reset in the middle of a read
        do_reset();
        send_pkt(13'd1, 9'd2, 64'hC0);
        do_read(rd);
        check("rstmid_first", rd, 64'hC0);
        in_rd_packet_req = 1'b1;
        @(negedge clk);
        in_rd_packet_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_empty", 64'(out_packet_buffer_empty), 64'd1);
        check("rstmid_out", out_packet_data_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        do_read(rd);
        check("rstmid_read_out", rd, 64'd0);
        check("rstmid_read_empty", 64'(out_packet_buffer_empty), 64'd1);
        send_pkt(13'd2, 9'd1, 64'hD0);
        do_read(rd);
        check("rstmid_new", rd, 64'hD0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
